gpio_scan_sram_ctrl: RTL and testbench

Parametrised successor to the testchip's GPIO scan-chain SRAM controller. It serially loads a command word (macro select plus per-port address, data, csb, web and wmask) from GPIO pins. On an execute strobe it issues one operation, or a burst of auto-incrementing operations, to the selected OpenRAM macro. It captures read data, optionally compares it on-chip against the scanned data, and shifts results back out. It sits between the GPIO pad logic and the SRAM select/mux fabric.

---
 rtl/gpio_scan_pkg.sv | 39 +++
 rtl/gpio_scan_port.sv | 50 +++++
 rtl/gpio_scan_sram_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_gpio_scan_sram_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_scan_pkg.sv
// Shared types and layout helpers for the GPIO scan-chain SRAM controller.
// Scan word, MSB first: sel, then port 0 .. port N-1, each {addr, din, csb, web, wmask}.
package gpio_scan_pkg;

  localparam int DEF_SEL_W     = 4;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_WMASK_W   = 4;
  localparam int DEF_NUM_PORTS = 2;
  localparam int DEF_CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  function automatic int port_w(input int addr_w, input int data_w, input int wmask_w);
    return addr_w + data_w + 2 + wmask_w;
  endfunction

  function automatic int scan_w(input int sel_w, input int num_ports, input int pw);
    return sel_w + num_ports * pw;
  endfunction

  // Port 0 sits directly below sel, so higher port numbers land at lower bits.
  function automatic int port_lsb(input int p, input int num_ports, input int pw);
    return (num_ports - 1 - p) * pw;
  endfunction

  function automatic int din_lsb(input int wmask_w);
    return wmask_w + 2;
  endfunction

  function automatic int addr_lsb(input int data_w, input int wmask_w);
    return wmask_w + 2 + data_w;
  endfunction

endpackage

// File: rtl/gpio_scan_port.sv
// One SRAM port slice: field decode, beat-offset address, captured read data
// and the compare-fail flag for this port.
module gpio_scan_port
  import gpio_scan_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int WMASK_W = DEF_WMASK_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic [ADDR_W+DATA_W+2+WMASK_W-1:0]  field_i,
  input  logic [CNT_W-1:0]                    beat_i,
  input  logic                                capture_i,
  input  logic [DATA_W-1:0]                   sram_dout_i,
  output logic [ADDR_W-1:0]                   addr_o,
  output logic [DATA_W-1:0]                   din_o,
  output logic                                csb_o,
  output logic                                web_o,
  output logic [WMASK_W-1:0]                  wmask_o,
  output logic [DATA_W-1:0]                   dout_o,
  output logic                                cmp_fail_o
);

  logic [DATA_W-1:0] dout_q;
  logic              is_read;

  assign wmask_o = field_i[WMASK_W-1:0];
  assign web_o   = field_i[WMASK_W];
  assign csb_o   = field_i[WMASK_W+1];
  assign din_o   = field_i[din_lsb(WMASK_W) +: DATA_W];
  // Address wraps naturally at 2^ADDR_W.
  assign addr_o  = field_i[addr_lsb(DATA_W, WMASK_W) +: ADDR_W] + ADDR_W'(beat_i);

  assign is_read    = !csb_o && web_o;
  // Only read beats carry meaningful dout, so only they can fail a compare.
  assign cmp_fail_o = is_read && (sram_dout_i != din_o);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dout_q <= '0;
    end else if (capture_i && is_read) begin
      dout_q <= sram_dout_i;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/gpio_scan_sram_ctrl.sv
// GPIO scan-chain SRAM controller: serial command load, single or burst
// execution against the selected macro, read capture, on-chip compare.
module gpio_scan_sram_ctrl
  import gpio_scan_pkg::*;
#(
  parameter int SEL_W     = DEF_SEL_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int WMASK_W   = DEF_WMASK_W,
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          scan_en,
  input  logic                                          scan_in,
  output logic                                          scan_out,
  input  logic                                          sram_load,
  input  logic                                          global_csb,
  input  logic [CNT_W-1:0]                              burst_len,
  input  logic                                          cmp_en,
  output logic                                          busy,
  output logic                                          mismatch,
  output logic [ADDR_W-1:0]                             fail_addr,
  output logic [$clog2(NUM_PORTS > 1 ? NUM_PORTS : 2)-1:0] fail_port,
  output logic [SEL_W-1:0]                              sram_sel,
  output logic [NUM_PORTS-1:0]                          sram_csb,
  output logic [NUM_PORTS-1:0]                          sram_web,
  output logic [NUM_PORTS*WMASK_W-1:0]                  sram_wmask,
  output logic [NUM_PORTS*ADDR_W-1:0]                   sram_addr,
  output logic [NUM_PORTS*DATA_W-1:0]                   sram_din,
  input  logic [NUM_PORTS*DATA_W-1:0]                   sram_dout,
  output state_e                                        state_dbg
);

  localparam int PORT_W  = port_w(ADDR_W, DATA_W, WMASK_W);
  localparam int SCAN_W  = scan_w(SEL_W, NUM_PORTS, PORT_W);
  localparam int FP_W    = $clog2(NUM_PORTS > 1 ? NUM_PORTS : 2);
  localparam int DIN_LSB = din_lsb(WMASK_W);

  state_e                             state_q;
  logic [SCAN_W-1:0]                  scan_q;
  logic [SCAN_W-1:0]                  load_word;
  logic [CNT_W-1:0]                   beat_q, len_q, beat_inc, beat_sel;
  logic                               gcsb_q;
  logic                               mismatch_q;
  logic [ADDR_W-1:0]                  fail_addr_q;
  logic [FP_W-1:0]                    fail_port_q;
  logic [SEL_W-1:0]                   sel_q;
  logic [NUM_PORTS-1:0]               csb_q, web_q;
  logic [NUM_PORTS-1:0][WMASK_W-1:0]  wmask_q;
  logic [NUM_PORTS-1:0][ADDR_W-1:0]   addr_q;
  logic [NUM_PORTS-1:0][DATA_W-1:0]   din_q;

  logic [NUM_PORTS-1:0][ADDR_W-1:0]   p_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0]   p_din, p_dout;
  logic [NUM_PORTS-1:0][WMASK_W-1:0]  p_wmask;
  logic [NUM_PORTS-1:0]               p_csb, p_web, p_fail;
  logic                               capture;
  logic                               any_fail;
  logic [FP_W-1:0]                    first_port;

  assign capture  = (state_q == ST_CAPTURE);
  assign beat_inc = beat_q + CNT_W'(1);
  // Port slices see the beat of the *next* issue: 0 at start, beat+1 from CAPTURE.
  assign beat_sel = capture ? beat_inc : '0;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    gpio_scan_port #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .WMASK_W (WMASK_W),
      .CNT_W   (CNT_W)
    ) u_port (
      .clk_i       (clk),
      .reset_i     (reset),
      .field_i     (scan_q[port_lsb(p, NUM_PORTS, PORT_W) +: PORT_W]),
      .beat_i      (beat_sel),
      .capture_i   (capture),
      .sram_dout_i (sram_dout[p*DATA_W +: DATA_W]),
      .addr_o      (p_addr[p]),
      .din_o       (p_din[p]),
      .csb_o       (p_csb[p]),
      .web_o       (p_web[p]),
      .wmask_o     (p_wmask[p]),
      .dout_o      (p_dout[p]),
      .cmp_fail_o  (p_fail[p])
    );
  end

  always_comb begin
    load_word = scan_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      load_word[port_lsb(p, NUM_PORTS, PORT_W) + DIN_LSB +: DATA_W] = p_dout[p];
    end
  end

  // Scan downwards so the lowest failing port is the one left standing.
  always_comb begin
    any_fail   = 1'b0;
    first_port = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (p_fail[p]) begin
        any_fail   = 1'b1;
        first_port = FP_W'(p);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      scan_q      <= '0;
      beat_q      <= '0;
      len_q       <= CNT_W'(1);
      gcsb_q      <= 1'b1;
      mismatch_q  <= 1'b0;
      fail_addr_q <= '0;
      fail_port_q <= '0;
      sel_q       <= '0;
      csb_q       <= '1;
      web_q       <= '1;
      wmask_q     <= '0;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      gcsb_q <= global_csb;
      case (state_q)
        ST_IDLE: begin
          if (scan_en) begin
            scan_q <= {scan_q[SCAN_W-2:0], scan_in};
          end else if (sram_load) begin
            scan_q <= load_word;
          end else if (gcsb_q && !global_csb) begin
            beat_q      <= '0;
            len_q       <= (burst_len == '0) ? CNT_W'(1) : burst_len;
            mismatch_q  <= 1'b0;
            fail_addr_q <= '0;
            fail_port_q <= '0;
            sel_q       <= scan_q[SCAN_W-1 -: SEL_W];
            csb_q       <= p_csb;
            web_q       <= p_web;
            wmask_q     <= p_wmask;
            addr_q      <= p_addr;
            din_q       <= p_din;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          csb_q   <= '1;
          web_q   <= '1;
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // addr_q still holds this beat's issued address.
          if (cmp_en && any_fail) begin
            mismatch_q <= 1'b1;
            if (!mismatch_q) begin
              fail_addr_q <= addr_q[first_port];
              fail_port_q <= first_port;
            end
          end
          beat_q <= beat_inc;
          if (beat_inc == len_q) begin
            state_q <= ST_IDLE;
          end else begin
            csb_q   <= p_csb;
            web_q   <= p_web;
            wmask_q <= p_wmask;
            addr_q  <= p_addr;
            din_q   <= p_din;
            state_q <= ST_ISSUE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign scan_out   = scan_q[SCAN_W-1];
  assign busy       = (state_q != ST_IDLE);
  assign mismatch   = mismatch_q;
  assign fail_addr  = fail_addr_q;
  assign fail_port  = fail_port_q;
  assign sram_sel   = sel_q;
  assign sram_csb   = csb_q;
  assign sram_web   = web_q;
  assign sram_wmask = wmask_q;
  assign sram_addr  = addr_q;
  assign sram_din   = din_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_gpio_scan_sram_ctrl.sv
// Bench for gpio_scan_sram_ctrl: a memory model answers the SRAM pins and a
// beat-by-beat reference predicts addresses, read-back words and compare results.
module tb_gpio_scan_sram_ctrl;
  import gpio_scan_pkg::*;

  typedef struct packed {
    logic [3:0]       sel;
    logic [1:0][15:0] addr;
    logic [1:0][31:0] din;
    logic [1:0]       csb;
    logic [1:0]       web;
    logic [1:0][3:0]  wmask;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset, scan_en, scan_in, sram_load, global_csb, cmp_en;
  logic [7:0]  burst_len;
  logic        scan_out, busy, mismatch;
  logic [15:0] fail_addr;
  logic        fail_port;
  logic [3:0]  sram_sel;
  logic [1:0]  sram_csb, sram_web;
  logic [7:0]  sram_wmask;
  logic [31:0] sram_addr;
  logic [63:0] sram_din, sram_dout;
  state_e      state_dbg;

  int n_vec, n_err;

  gpio_scan_sram_ctrl dut (
    .clk(clk), .reset(reset), .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
    .sram_load(sram_load), .global_csb(global_csb), .burst_len(burst_len), .cmp_en(cmp_en),
    .busy(busy), .mismatch(mismatch), .fail_addr(fail_addr), .fail_port(fail_port),
    .sram_sel(sram_sel), .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- SRAM environment model ----------------
  logic [31:0] env_mem [int];
  logic [15:0] issued_q[$];
  logic        corrupt_en, corrupt_port;
  logic [15:0] corrupt_addr;

  always @(posedge clk) begin
    int          k;
    logic [31:0] w;
    logic [15:0] a;
    for (int p = 0; p < 2; p++) begin
      if (!sram_csb[p]) begin
        a = sram_addr[p*16 +: 16];
        k = int'(sram_sel) * 65536 + int'(a);
        issued_q.push_back(a);
        w = env_mem.exists(k) ? env_mem[k] : 32'h0;
        if (!sram_web[p]) begin
          for (int i = 0; i < 4; i++)
            if (sram_wmask[p*4 + i]) w[8*i +: 8] = sram_din[p*32 + 8*i +: 8];
          env_mem[k] = w;
        end else begin
          if (corrupt_en && corrupt_port == p[0] && corrupt_addr == a) w = ~w;
          sram_dout[p*32 +: 32] <= w;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0]      ref_mem [int];
  logic [1:0][31:0] ref_last;
  logic             exp_mm, exp_fp;
  logic [15:0]      exp_fa;
  logic [15:0]      exp_q[$];

  task automatic ref_exec(input cmd_t c, input int len, input bit cmp);
    int          k;
    logic [31:0] w;
    logic [15:0] a;
    exp_mm = 1'b0; exp_fa = '0; exp_fp = 1'b0;
    if (len == 0) len = 1;
    for (int b = 0; b < len; b++) begin
      for (int p = 0; p < 2; p++) begin
        if (!c.csb[p]) begin
          a = c.addr[p] + 16'(b);
          exp_q.push_back(a);
          k = int'(c.sel) * 65536 + int'(a);
          w = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
          if (!c.web[p]) begin
            for (int i = 0; i < 4; i++)
              if (c.wmask[p][i]) w[8*i +: 8] = c.din[p][8*i +: 8];
            ref_mem[k] = w;
          end else begin
            if (corrupt_en && corrupt_port == p[0] && corrupt_addr == a) w = ~w;
            ref_last[p] = w;
            if (cmp && w != c.din[p] && !exp_mm) begin
              exp_mm = 1'b1; exp_fa = a; exp_fp = p[0];
            end
          end
        end
      end
    end
  endtask

  function automatic logic [111:0] pack(input cmd_t c);
    logic [111:0] w;
    w = '0;
    w[111:108] = c.sel;
    for (int p = 0; p < 2; p++)
      w[(1-p)*54 +: 54] = {c.addr[p], c.din[p], c.csb[p], c.web[p], c.wmask[p]};
    return w;
  endfunction

  function automatic cmd_t idle_cmd(input logic [3:0] sel);
    cmd_t c;
    c = '0;
    c.sel = sel; c.csb = 2'b11; c.web = 2'b11;
    return c;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic scan_word(input logic [111:0] w, output logic [111:0] got);
    for (int i = 111; i >= 0; i--) begin
      @(negedge clk);
      got[i]  = scan_out;
      scan_en = 1'b1;
      scan_in = w[i];
    end
    @(negedge clk);
    scan_en = 1'b0;
    scan_in = 1'b0;
  endtask

  task automatic exec(input cmd_t c, input int len, input bit cmp, input bit disturb, input string tag);
    logic [111:0] dummy;
    int cyc, exp_cyc;
    scan_word(pack(c), dummy);
    exp_q.delete();
    issued_q.delete();
    ref_exec(c, len, cmp);
    exp_cyc = 2 * ((len == 0) ? 1 : len);
    @(negedge clk);
    burst_len = 8'(len); cmp_en = cmp; global_csb = 1'b0;
    @(negedge clk);
    global_csb = 1'b1;
    n_vec++;
    if (mismatch !== 1'b0) begin
      n_err++; $display("FAIL %s mismatch_cleared_at_start: got %b expected 0", tag, mismatch);
    end
    cyc = 0;
    while (busy && cyc < 1000) begin
      cyc++;
      if (disturb) begin
        scan_en    = 1'($urandom_range(0, 1));
        scan_in    = 1'($urandom_range(0, 1));
        global_csb = 1'($urandom_range(0, 1));
        sram_load  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    scan_en = 1'b0; sram_load = 1'b0; global_csb = 1'b1;
    n_vec++;
    if (cyc != exp_cyc) begin
      n_err++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, cyc, exp_cyc);
    end
    n_vec++;
    if (issued_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL %s issue_count: got %0d expected %0d", tag, issued_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_vec++;
        if (issued_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL %s issued_addr[%0d]: got %h expected %h", tag, i, issued_q[i], exp_q[i]);
        end
      end
    end
    n_vec++;
    if (mismatch !== exp_mm || fail_addr !== exp_fa || fail_port !== exp_fp) begin
      n_err++;
      $display("FAIL %s compare_result: got mm=%b fa=%h fp=%b expected mm=%b fa=%h fp=%b",
               tag, mismatch, fail_addr, fail_port, exp_mm, exp_fa, exp_fp);
    end
  endtask

  task automatic read_back(input cmd_t c, input string tag);
    cmd_t         e;
    logic [111:0] got;
    e = c;
    e.din = ref_last;
    @(negedge clk); sram_load = 1'b1;
    @(negedge clk); sram_load = 1'b0;
    scan_word('0, got);
    n_vec++;
    if (got !== pack(e)) begin
      n_err++; $display("FAIL %s scan_word: got %h expected %h", tag, got, pack(e));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_vec++; if (scan_out !== 1'b0) begin n_err++; $display("FAIL rst scan_out: got %b expected 0", scan_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst busy: got %b expected 0", busy); end
    n_vec++; if (mismatch !== 1'b0 || fail_addr !== 16'h0 || fail_port !== 1'b0) begin
      n_err++; $display("FAIL rst fail_regs: got %b %h %b expected 0 0000 0", mismatch, fail_addr, fail_port); end
    n_vec++; if (sram_csb !== 2'b11 || sram_web !== 2'b11) begin
      n_err++; $display("FAIL rst csb_web: got %b %b expected 11 11", sram_csb, sram_web); end
    n_vec++; if (sram_sel !== 4'h0 || sram_addr !== 32'h0 || sram_din !== 64'h0 || sram_wmask !== 8'h0) begin
      n_err++; $display("FAIL rst sram_bus: got sel=%h addr=%h din=%h wm=%h expected zeros", sram_sel, sram_addr, sram_din, sram_wmask); end
    n_vec++; if (state_dbg !== ST_IDLE) begin n_err++; $display("FAIL rst state: got %0d expected %0d", state_dbg, ST_IDLE); end
  endtask

  task automatic test_write_read();
    cmd_t w, r;
    w = idle_cmd(4'd3);
    w.addr[0] = 16'h0001; w.din[0] = 32'hDEADBEEF; w.csb[0] = 1'b0; w.web[0] = 1'b0; w.wmask[0] = 4'hF;
    exec(w, 1, 1'b0, 1'b0, "wr_write");
    n_vec++; if (sram_sel !== 4'd3) begin n_err++; $display("FAIL wr_sel: got %h expected 3", sram_sel); end
    r = w; r.web[0] = 1'b1; r.din[0] = 32'h0;
    exec(r, 1, 1'b0, 1'b0, "wr_read");
    read_back(r, "wr_readback");
    n_vec++; if (ref_last[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_model_data: got %h expected deadbeef", ref_last[0]); end
  endtask

  task automatic test_dual_read();
    cmd_t w, r;
    w = idle_cmd(4'd3);
    w.addr[0] = 16'h0001; w.din[0] = $urandom; w.csb[0] = 1'b0; w.web[0] = 1'b0; w.wmask[0] = 4'hF;
    w.addr[1] = 16'h0002; w.din[1] = $urandom; w.csb[1] = 1'b0; w.web[1] = 1'b0; w.wmask[1] = 4'hF;
    exec(w, 1, 1'b0, 1'b0, "dual_write");
    r = w; r.web = 2'b11; r.din = '0; r.wmask[0] = 4'($urandom); r.wmask[1] = 4'($urandom);
    exec(r, 1, 1'b0, 1'b0, "dual_read");
    read_back(r, "dual_readback");
  endtask

  task automatic test_burst();
    cmd_t w, r;
    logic [15:0] want [4];
    want = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    w = idle_cmd(4'd3);
    w.addr[0] = 16'hFFFE; w.din[0] = 32'h5A5A5A5A; w.csb[0] = 1'b0; w.web[0] = 1'b0; w.wmask[0] = 4'hF;
    exec(w, 4, 1'b0, 1'b0, "burst_write");
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (issued_q.size() <= i || issued_q[i] !== want[i]) begin
        n_err++; $display("FAIL burst_wrap_addr[%0d]: got %h expected %h", i, (issued_q.size() > i) ? issued_q[i] : 16'hxxxx, want[i]);
      end
    end
    r = w; r.web[0] = 1'b1;
    exec(r, 4, 1'b1, 1'b0, "burst_cmp");
    n_vec++; if (mismatch !== 1'b0) begin n_err++; $display("FAIL burst_no_mismatch: got %b expected 0", mismatch); end
  endtask

  task automatic test_mismatch();
    cmd_t w, r;
    logic [31:0] d;
    d = $urandom;
    w = idle_cmd(4'd3);
    w.addr[1] = 16'h0000; w.din[1] = d; w.csb[1] = 1'b0; w.web[1] = 1'b0; w.wmask[1] = 4'hF;
    exec(w, 4, 1'b0, 1'b0, "mm_write");
    corrupt_en = 1'b1; corrupt_port = 1'b1; corrupt_addr = 16'h0002;
    r = w; r.web[1] = 1'b1;
    r.addr[0] = 16'h0100; r.din[0] = 32'h0; r.csb[0] = 1'b0; r.web[0] = 1'b1; r.wmask[0] = 4'h0;
    exec(r, 4, 1'b1, 1'b0, "mm_cmp");
    corrupt_en = 1'b0;
    n_vec++;
    if (mismatch !== 1'b1 || fail_addr !== 16'h0002 || fail_port !== 1'b1) begin
      n_err++; $display("FAIL mm_first_fail: got mm=%b fa=%h fp=%b expected 1 0002 1", mismatch, fail_addr, fail_port);
    end
    exec(r, 4, 1'b0, 1'b0, "mm_clear");
  endtask

  task automatic test_busy_ignore();
    cmd_t         c;
    logic [111:0] got;
    c = idle_cmd(4'd3);
    c.addr[0] = 16'hFFFE; c.din[0] = $urandom; c.csb[0] = 1'b0; c.web[0] = 1'b1; c.wmask[0] = 4'($urandom);
    exec(c, 4, 1'b0, 1'b1, "busy_ign");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_ign_no_restart[%0d]: got %b expected 0", i, busy); end
    end
    scan_word('0, got);
    n_vec++; if (got !== pack(c)) begin n_err++; $display("FAIL busy_ign_scan_kept: got %h expected %h", got, pack(c)); end
  endtask

  task automatic test_reset_mid();
    cmd_t         c;
    logic [111:0] dummy;
    c = idle_cmd(4'd3);
    c.addr[0] = 16'h0010; c.csb[0] = 1'b0; c.web[0] = 1'b1; c.wmask[0] = 4'hA; c.din[0] = 32'h1234_5678;
    scan_word(pack(c), dummy);
    issued_q.delete();
    @(negedge clk); burst_len = 8'd4; cmp_en = 1'b0; global_csb = 1'b0;
    @(negedge clk); global_csb = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++; if (busy !== 1'b1 || sram_csb !== 2'b10) begin
      n_err++; $display("FAIL rmid_beat2_issue: got busy=%b csb=%b expected 1 10", busy, sram_csb); end
    reset = 1'b1;
    @(negedge clk);
    n_vec++; if (sram_csb !== 2'b11 || busy !== 1'b0) begin
      n_err++; $display("FAIL rmid_stop: got csb=%b busy=%b expected 11 0", sram_csb, busy); end
    n_vec++; if (scan_out !== 1'b0 || sram_web !== 2'b11 || sram_sel !== 4'h0 || sram_addr !== 32'h0 ||
                 sram_din !== 64'h0 || sram_wmask !== 8'h0 || mismatch !== 1'b0 || fail_addr !== 16'h0 || fail_port !== 1'b0) begin
      n_err++; $display("FAIL rmid_reset_vals: got so=%b web=%b sel=%h addr=%h din=%h wm=%h mm=%b fa=%h fp=%b expected reset values",
                        scan_out, sram_web, sram_sel, sram_addr, sram_din, sram_wmask, mismatch, fail_addr, fail_port); end
    reset = 1'b0;
    ref_last = '0;
    repeat (4) @(negedge clk);
    n_vec++; if (issued_q.size() != 3 || busy !== 1'b0) begin
      n_err++; $display("FAIL rmid_no_more_beats: got issues=%0d busy=%b expected 3 0", issued_q.size(), busy); end
  endtask

  task automatic test_random();
    cmd_t c;
    int   len;
    bit   cmp;
    for (int n = 0; n < 8; n++) begin
      c = '0;
      c.sel = 4'($urandom_range(0, 15));
      for (int p = 0; p < 2; p++) begin
        c.csb[p]   = ($urandom_range(0, 3) == 0);
        c.web[p]   = 1'($urandom_range(0, 1));
        c.wmask[p] = 4'($urandom);
        c.din[p]   = $urandom;
        c.addr[p]  = (p == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom_range(64, 79));
      end
      len = $urandom_range(0, 3);
      cmp = 1'($urandom_range(0, 1));
      exec(c, len, cmp, 1'b0, $sformatf("rand%0d", n));
      read_back(c, $sformatf("rand%0d_readback", n));
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; scan_en = 1'b0; scan_in = 1'b0; sram_load = 1'b0;
    global_csb = 1'b1; cmp_en = 1'b0; burst_len = 8'd1;
    corrupt_en = 1'b0; corrupt_port = 1'b0; corrupt_addr = '0;
    ref_last = '0;
    test_reset();
    test_write_read();
    test_dual_read();
    test_burst();
    test_mismatch();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
